lix_en_fifo: RTL

LIX_EN_FIFO -- requirements
Module: lix_en_fifo

---
 rtl/lix_en_fifo_if.sv | 28 ++
 rtl/lix_en_fifo.sv | 71 +++++++
 2 files changed

// File: rtl/lix_en_fifo_if.sv
// Handshake bundle between an enable-stalled upstream pipeline, the FIFO
// and its downstream consumer.
interface lix_en_fifo_if #(
  parameter int W = 32,
  parameter int D = 8
);
  logic                 i_vld;
  logic [W-1:0]         i_x;
  logic                 o_en;
  logic                 i_clr;
  logic                 o_vld;
  logic                 i_rdy;
  logic [W-1:0]         o_z;
  logic [$clog2(D):0]   o_lvl;
  logic                 o_afull;

  // FIFO side: takes upstream data and downstream ready, drives status and head
  modport slave (
    input  i_vld, i_x, i_clr, i_rdy,
    output o_en, o_vld, o_z, o_lvl, o_afull
  );

  // Environment side: the upstream pipeline plus the downstream consumer
  modport master (
    output i_vld, i_x, i_clr, i_rdy,
    input  o_en, o_vld, o_z, o_lvl, o_afull
  );
endinterface

// File: rtl/lix_en_fifo.sv
// First-word-fall-through FIFO that back-pressures an enable-stalled
// pipeline. o_en depends only on registered occupancy and the flush input,
// so an item frozen upstream is never written twice.
module lix_en_fifo #(
  parameter int W  = 32,
  parameter int D  = 8,
  parameter int AF = 6
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  lix_en_fifo_if.slave   bus
);

  localparam int           AW    = $clog2(D);
  localparam logic [AW:0]  DEPTH = (AW+1)'(D);
  localparam logic [AW:0]  THR   = (AW+1)'(AF);

  logic [W-1:0]  mem [D];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   cnt;
  logic          en;
  logic          vld;
  logic          wr;
  logic          rd;

  assign en  = (cnt < DEPTH) && !bus.i_clr;
  assign vld = (cnt != '0);
  // A flush cycle suppresses both sides; en already blocks the write.
  assign wr  = bus.i_vld && en;
  assign rd  = vld && bus.i_rdy && !bus.i_clr;

  assign bus.o_en    = en;
  assign bus.o_vld   = vld;
  assign bus.o_z     = mem[rd_ptr];
  assign bus.o_lvl   = cnt;
  assign bus.o_afull = (cnt >= THR);

  // Storage array: written on accepted items only, never reset
  always_ff @(posedge clk_i) begin
    if (wr) begin
      mem[wr_ptr] <= bus.i_x;
    end
  end

  // Pointers and occupancy: flush clears, otherwise track reads and writes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (bus.i_clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (wr && !rd) begin
        cnt <= cnt + (AW+1)'(1);
      end else if (rd && !wr) begin
        cnt <= cnt - (AW+1)'(1);
      end
    end
  end

endmodule
